// File: rtl/e203_ifu_flush_rsp.sv
// ---------------------------------------------------------------------------
// e203_ifu_flush_rsp
//
// IFU-side responder for the EXU commit flush interface. A flush request
// carries two adder operands whose sum is the redirect PC. The block
// acknowledges the flush, issues one fetch to the redirect target, and drops
// the bus responses that belong to fetches issued before the flush.
//
// It sits between the IFU PC generator / fetch bus port (upstream) and the
// mini-decode / IR stage (downstream).
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   pipe_flush_*          flush request from commit (req/ack, two operands)
//   seq_req_*             sequential fetch request from the PC generator
//   ifu_req_*             fetch request to the bus port
//   ifu_rsp_*             fetch response from the bus port
//   o_rsp_*               response forwarded to mini-decode / IR
//   redirect_valid/_pc    one-cycle pulse when the redirect fetch is issued
//   busy                  a redirect is pending or stale responses are owed
// ---------------------------------------------------------------------------
module e203_ifu_flush_rsp #(
  parameter int PC_W     = 32,
  parameter int INSTR_W  = 32,
  parameter int OUTS_MAX = 2
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               pipe_flush_req,
  input  logic [PC_W-1:0]    pipe_flush_add_op1,
  input  logic [PC_W-1:0]    pipe_flush_add_op2,
  output logic               pipe_flush_ack,

  input  logic               seq_req_valid,
  input  logic [PC_W-1:0]    seq_req_pc,
  output logic               seq_req_ready,

  output logic               ifu_req_valid,
  output logic [PC_W-1:0]    ifu_req_pc,
  input  logic               ifu_req_ready,

  input  logic               ifu_rsp_valid,
  input  logic [INSTR_W-1:0] ifu_rsp_instr,
  input  logic               ifu_rsp_err,
  output logic               ifu_rsp_ready,

  output logic               o_rsp_valid,
  output logic [INSTR_W-1:0] o_rsp_instr,
  output logic               o_rsp_err,
  input  logic               o_rsp_ready,

  output logic               redirect_valid,
  output logic [PC_W-1:0]    redirect_pc,
  output logic               busy
);

  localparam int CNT_W = $clog2(OUTS_MAX + 1);

  typedef enum logic {
    IDLE = 1'b0,  // no redirect pending; sequential fetches flow through
    PEND = 1'b1   // redirect accepted, fetch to flush_pc_q not yet issued
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    flush_pc_q, flush_pc_d;
  logic [CNT_W-1:0]   outs_cnt_q, outs_cnt_d;
  logic [CNT_W-1:0]   discard_cnt_q, discard_cnt_d;

  logic               outs_full;
  logic               flush_accept;
  logic               req_hs;
  logic               rsp_hs;

  // The full check looks only at the registered count: a response retiring
  // this cycle does not free a slot until the next one.
  assign outs_full = (outs_cnt_q == CNT_W'(OUTS_MAX));

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    flush_pc_d     = flush_pc_q;
    outs_cnt_d     = outs_cnt_q;
    discard_cnt_d  = discard_cnt_q;

    pipe_flush_ack = 1'b0;
    flush_accept   = 1'b0;
    seq_req_ready  = 1'b0;
    ifu_req_valid  = 1'b0;
    ifu_req_pc     = seq_req_pc;
    redirect_valid = 1'b0;
    ifu_rsp_ready  = 1'b0;
    o_rsp_valid    = 1'b0;

    // Handshake-facing outputs are held low for the whole reset cycle so
    // nothing is issued or consumed while state is being cleared.
    if (rst_n) begin
      pipe_flush_ack = (state_q == IDLE);
      flush_accept   = pipe_flush_req && pipe_flush_ack;

      unique case (state_q)
        IDLE: begin
          if (pipe_flush_req) begin
            // Accept cycle: the sequential stream is stalled, and the
            // redirect fetch goes out no earlier than the next cycle.
            state_d    = PEND;
            flush_pc_d = pipe_flush_add_op1 + pipe_flush_add_op2;
          end else begin
            ifu_req_valid = seq_req_valid && !outs_full;
            seq_req_ready = ifu_req_ready && !outs_full;
          end
        end
        PEND: begin
          ifu_req_valid = !outs_full;
          ifu_req_pc    = flush_pc_q;
          if (!outs_full && ifu_req_ready) begin
            redirect_valid = 1'b1;
            state_d        = IDLE;
          end
        end
      endcase

      // Any response arriving in the accept cycle is already stale, as is
      // every response still owed while discard_cnt_q is non-zero.
      if (flush_accept || (discard_cnt_q != '0)) begin
        ifu_rsp_ready = 1'b1;
      end else begin
        ifu_rsp_ready = o_rsp_ready;
        o_rsp_valid   = ifu_rsp_valid;
      end
    end

    req_hs = ifu_req_valid && ifu_req_ready;
    rsp_hs = ifu_rsp_valid && ifu_rsp_ready;

    if (req_hs && !rsp_hs) begin
      outs_cnt_d = outs_cnt_q + CNT_W'(1);
    end else if (!req_hs && rsp_hs) begin
      outs_cnt_d = outs_cnt_q - CNT_W'(1);
    end

    // Responses return in order, so every fetch outstanding at the flush
    // (minus one retiring right now) is older than the redirect fetch.
    if (flush_accept) begin
      discard_cnt_d = outs_cnt_q - CNT_W'(rsp_hs);
    end else if ((discard_cnt_q != '0) && rsp_hs) begin
      discard_cnt_d = discard_cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    // NOTE: all four registers are control state and are cleared by reset;
    // a reset mid-operation abandons any pending redirect and discard debt.
    if (!rst_n) begin
      state_q       <= IDLE;
      flush_pc_q    <= '0;
      outs_cnt_q    <= '0;
      discard_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_pc_q    <= flush_pc_d;
      outs_cnt_q    <= outs_cnt_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  assign o_rsp_instr = ifu_rsp_instr;
  assign o_rsp_err   = ifu_rsp_err;
  assign redirect_pc = flush_pc_q;
  assign busy        = (state_q == PEND) || (discard_cnt_q != '0);

  // A response with nothing outstanding means the bus port broke protocol.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (ifu_rsp_valid && ifu_rsp_ready) |-> (outs_cnt_q != '0))
    else $error("ifu response handshake with no outstanding fetch");

endmodule

// File: tb/tb_e203_ifu_flush_rsp.sv
// ---------------------------------------------------------------------------
// tb_e203_ifu_flush_rsp
//
// Drives the flush responder through reset, redirect, wrap-around, stale
// response dropping and back-to-back flushes. Every fetch the bench expects
// to issue is pushed to a scoreboard with a stale flag; a flush marks all
// entries then outstanding as stale, and each returned response pops the
// head and decides whether it must be forwarded or dropped.
// ---------------------------------------------------------------------------
module tb_e203_ifu_flush_rsp;

  localparam int PC_W     = 32;
  localparam int INSTR_W  = 32;
  localparam int OUTS_MAX = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               pipe_flush_req;
  logic [PC_W-1:0]    pipe_flush_add_op1;
  logic [PC_W-1:0]    pipe_flush_add_op2;
  logic               pipe_flush_ack;
  logic               seq_req_valid;
  logic [PC_W-1:0]    seq_req_pc;
  logic               seq_req_ready;
  logic               ifu_req_valid;
  logic [PC_W-1:0]    ifu_req_pc;
  logic               ifu_req_ready;
  logic               ifu_rsp_valid;
  logic [INSTR_W-1:0] ifu_rsp_instr;
  logic               ifu_rsp_err;
  logic               ifu_rsp_ready;
  logic               o_rsp_valid;
  logic [INSTR_W-1:0] o_rsp_instr;
  logic               o_rsp_err;
  logic               o_rsp_ready;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [PC_W-1:0] pc;
    bit              stale;
  } exp_t;

  exp_t sb[$];

  e203_ifu_flush_rsp #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .OUTS_MAX(OUTS_MAX)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pipe_flush_req    (pipe_flush_req),
    .pipe_flush_add_op1(pipe_flush_add_op1),
    .pipe_flush_add_op2(pipe_flush_add_op2),
    .pipe_flush_ack    (pipe_flush_ack),
    .seq_req_valid     (seq_req_valid),
    .seq_req_pc        (seq_req_pc),
    .seq_req_ready     (seq_req_ready),
    .ifu_req_valid     (ifu_req_valid),
    .ifu_req_pc        (ifu_req_pc),
    .ifu_req_ready     (ifu_req_ready),
    .ifu_rsp_valid     (ifu_rsp_valid),
    .ifu_rsp_instr     (ifu_rsp_instr),
    .ifu_rsp_err       (ifu_rsp_err),
    .ifu_rsp_ready     (ifu_rsp_ready),
    .o_rsp_valid       (o_rsp_valid),
    .o_rsp_instr       (o_rsp_instr),
    .o_rsp_err         (o_rsp_err),
    .o_rsp_ready       (o_rsp_ready),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  // Fetch data the bench's bus model returns for a given address.
  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  // Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    pipe_flush_req     = 1'b0;
    pipe_flush_add_op1 = '0;
    pipe_flush_add_op2 = '0;
    seq_req_valid      = 1'b0;
    seq_req_pc         = '0;
    ifu_req_ready      = 1'b0;
    ifu_rsp_valid      = 1'b0;
    ifu_rsp_instr      = '0;
    ifu_rsp_err        = 1'b0;
    o_rsp_ready        = 1'b1;
  endtask

  task automatic mark_stale();
    foreach (sb[i]) sb[i].stale = 1'b1;
  endtask

  // One sequential fetch accepted by the bus port this cycle.
  task automatic issue_seq(input logic [PC_W-1:0] pc);
    seq_req_valid = 1'b1;
    seq_req_pc    = pc;
    ifu_req_ready = 1'b1;
    settle();
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_pc !== pc || seq_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL seq_issue: valid=%b pc=%h seq_ready=%b, expected valid=1 pc=%h seq_ready=1",
               ifu_req_valid, ifu_req_pc, seq_req_ready, pc);
    end
    sb.push_back('{pc: pc, stale: 1'b0});
    tick();
    seq_req_valid = 1'b0;
    ifu_req_ready = 1'b0;
  endtask

  // Flush presented in IDLE: acked with zero latency, no fetch that cycle.
  task automatic accept_flush(input logic [PC_W-1:0] op1, input logic [PC_W-1:0] op2);
    pipe_flush_req     = 1'b1;
    pipe_flush_add_op1 = op1;
    pipe_flush_add_op2 = op2;
    settle();
    checks++;
    if (pipe_flush_ack !== 1'b1 || ifu_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_accept: ack=%b req_valid=%b, expected ack=1 req_valid=0",
               pipe_flush_ack, ifu_req_valid);
    end
    mark_stale();
    tick();
    pipe_flush_req = 1'b0;
  endtask

  // Redirect fetch taken by the bus port this cycle.
  task automatic issue_redirect(input logic [PC_W-1:0] target);
    ifu_req_ready = 1'b1;
    settle();
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_pc !== target ||
        redirect_valid !== 1'b1 || redirect_pc !== target) begin
      failures++;
      $display("FAIL redirect_issue: valid=%b pc=%h rv=%b rpc=%h, expected 1 %h 1 %h",
               ifu_req_valid, ifu_req_pc, redirect_valid, redirect_pc, target, target);
    end
    sb.push_back('{pc: target, stale: 1'b0});
    tick();
    ifu_req_ready = 1'b0;
  endtask

  // The bus model returns the oldest outstanding fetch.
  task automatic return_rsp();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL rsp_order: scoreboard empty when a response was due");
      return;
    end
    e = sb.pop_front();
    ifu_rsp_valid = 1'b1;
    ifu_rsp_instr = instr_of(e.pc);
    ifu_rsp_err   = 1'b0;
    settle();
    if (o_rsp_valid !== !e.stale || ifu_rsp_ready !== 1'b1 ||
        (!e.stale && o_rsp_instr !== instr_of(e.pc))) begin
      failures++;
      $display("FAIL rsp_%0s pc=%h: o_valid=%b rsp_ready=%b instr=%h, expected o_valid=%b rsp_ready=1 instr=%h",
               e.stale ? "drop" : "fwd", e.pc, o_rsp_valid, ifu_rsp_ready, o_rsp_instr,
               !e.stale, instr_of(e.pc));
    end
    tick();
    ifu_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n          = 1'b0;
    seq_req_valid  = 1'b1;
    seq_req_pc     = 32'h0000_0040;
    ifu_req_ready  = 1'b1;
    pipe_flush_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (ifu_req_valid !== 1'b0 || seq_req_ready !== 1'b0 || pipe_flush_ack !== 1'b0 ||
          redirect_valid !== 1'b0 || o_rsp_valid !== 1'b0 || ifu_rsp_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: req_valid=%b seq_ready=%b ack=%b rv=%b o_valid=%b rsp_ready=%b, expected all 0",
                 c, ifu_req_valid, seq_req_ready, pipe_flush_ack, redirect_valid,
                 o_rsp_valid, ifu_rsp_ready);
      end
    end
    clear_inputs();
    rst_n = 1'b1;
    settle();
    checks++;
    if (pipe_flush_ack !== 1'b1 || busy !== 1'b0 || redirect_pc !== '0) begin
      failures++;
      $display("FAIL reset_release: ack=%b busy=%b rpc=%h, expected ack=1 busy=0 rpc=0",
               pipe_flush_ack, busy, redirect_pc);
    end
  endtask

  task automatic test_redirect();
    accept_flush(32'h8000_0000, 32'h0000_0100);
    issue_redirect(32'h8000_0100);
    settle();
    checks++;
    if (redirect_valid !== 1'b0 || busy !== 1'b0 || pipe_flush_ack !== 1'b1) begin
      failures++;
      $display("FAIL redirect_pulse: rv=%b busy=%b ack=%b, expected rv=0 busy=0 ack=1",
               redirect_valid, busy, pipe_flush_ack);
    end
    return_rsp();
  endtask

  task automatic test_wrap();
    accept_flush(32'hFFFF_FFF0, 32'h0000_0020);
    ifu_req_ready = 1'b0;
    settle();
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h0000_0010 ||
        redirect_valid !== 1'b0 || pipe_flush_ack !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL wrap_hold: valid=%b pc=%h rv=%b ack=%b busy=%b, expected 1 00000010 0 0 1",
               ifu_req_valid, ifu_req_pc, redirect_valid, pipe_flush_ack, busy);
    end
    tick();
    issue_redirect(32'h0000_0010);
    return_rsp();
  endtask

  task automatic test_outstanding_drop();
    issue_seq(32'h0000_0100);
    issue_seq(32'h0000_0104);
    seq_req_valid = 1'b1;
    seq_req_pc    = 32'h0000_0108;
    ifu_req_ready = 1'b1;
    settle();
    checks++;
    if (ifu_req_valid !== 1'b0 || seq_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL outs_full_seq: req_valid=%b seq_ready=%b, expected 0 0",
               ifu_req_valid, seq_req_ready);
    end
    seq_req_valid = 1'b0;
    ifu_req_ready = 1'b0;
    accept_flush(32'h0000_0200, 32'h0000_0000);
    // Redirect blocked while full, including the cycle the first stale
    // response retires.
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_instr = instr_of(sb[0].pc);
    settle();
    checks++;
    if (ifu_req_valid !== 1'b0 || busy !== 1'b1 || o_rsp_valid !== 1'b0 ||
        ifu_rsp_ready !== 1'b1 || !sb[0].stale) begin
      failures++;
      $display("FAIL outs_full_redirect: req_valid=%b busy=%b o_valid=%b rsp_ready=%b, expected 0 1 0 1",
               ifu_req_valid, busy, o_rsp_valid, ifu_rsp_ready);
    end
    void'(sb.pop_front());
    tick();
    ifu_rsp_valid = 1'b0;
    issue_redirect(32'h0000_0200);
    return_rsp();
    settle();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_drop: busy=%b, expected 0", busy);
    end
    return_rsp();
  endtask

  task automatic test_rsp_in_accept();
    issue_seq(32'h0000_0300);
    pipe_flush_req     = 1'b1;
    pipe_flush_add_op1 = 32'h0000_0200;
    pipe_flush_add_op2 = 32'h0000_0000;
    ifu_rsp_valid      = 1'b1;
    ifu_rsp_instr      = instr_of(32'h0000_0300);
    o_rsp_ready        = 1'b1;
    settle();
    checks++;
    if (pipe_flush_ack !== 1'b1 || ifu_rsp_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL accept_cycle_rsp: ack=%b rsp_ready=%b o_valid=%b, expected 1 1 0",
               pipe_flush_ack, ifu_rsp_ready, o_rsp_valid);
    end
    mark_stale();
    void'(sb.pop_front());
    tick();
    pipe_flush_req = 1'b0;
    ifu_rsp_valid  = 1'b0;
    issue_redirect(32'h0000_0200);
    settle();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL accept_cycle_discard: busy=%b, expected 0", busy);
    end
    return_rsp();
  endtask

  task automatic test_back_to_back();
    accept_flush(32'h0000_0400, 32'h0000_0000);
    pipe_flush_req     = 1'b1;
    pipe_flush_add_op1 = 32'h0000_0480;
    pipe_flush_add_op2 = 32'h0000_0080;
    ifu_req_ready      = 1'b0;
    settle();
    checks++;
    if (pipe_flush_ack !== 1'b0 || ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h0000_0400) begin
      failures++;
      $display("FAIL b2b_held: ack=%b valid=%b pc=%h, expected 0 1 00000400",
               pipe_flush_ack, ifu_req_valid, ifu_req_pc);
    end
    tick();
    ifu_req_ready = 1'b1;
    settle();
    checks++;
    if (pipe_flush_ack !== 1'b0 || redirect_valid !== 1'b1 || ifu_req_pc !== 32'h0000_0400) begin
      failures++;
      $display("FAIL b2b_first_issue: ack=%b rv=%b pc=%h, expected 0 1 00000400",
               pipe_flush_ack, redirect_valid, ifu_req_pc);
    end
    sb.push_back('{pc: 32'h0000_0400, stale: 1'b0});
    tick();
    ifu_req_ready = 1'b0;
    settle();
    checks++;
    if (pipe_flush_ack !== 1'b1 || ifu_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_accept: ack=%b req_valid=%b, expected 1 0",
               pipe_flush_ack, ifu_req_valid);
    end
    mark_stale();
    tick();
    pipe_flush_req = 1'b0;
    issue_redirect(32'h0000_0500);
    return_rsp();
    return_rsp();
    settle();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_backpressure();
    issue_seq(32'h0000_0600);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_instr = instr_of(32'h0000_0600);
    ifu_rsp_err   = 1'b1;
    o_rsp_ready   = 1'b0;
    settle();
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b1 || ifu_rsp_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall: o_valid=%b o_err=%b rsp_ready=%b, expected 1 1 0",
               o_rsp_valid, o_rsp_err, ifu_rsp_ready);
    end
    tick();
    o_rsp_ready = 1'b1;
    settle();
    checks++;
    if (ifu_rsp_ready !== 1'b1 || o_rsp_instr !== instr_of(32'h0000_0600)) begin
      failures++;
      $display("FAIL bp_release: rsp_ready=%b instr=%h, expected 1 %h",
               ifu_rsp_ready, o_rsp_instr, instr_of(32'h0000_0600));
    end
    void'(sb.pop_front());
    tick();
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
  endtask

  task automatic test_reset_midop();
    issue_seq(32'h0000_0700);
    accept_flush(32'h0000_0900, 32'h0000_0000);
    rst_n         = 1'b0;
    ifu_req_ready = 1'b1;
    settle();
    checks++;
    if (ifu_req_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset_issue: req_valid=%b rv=%b, expected 0 0",
               ifu_req_valid, redirect_valid);
    end
    tick();
    rst_n         = 1'b1;
    ifu_req_ready = 1'b0;
    sb.delete();
    settle();
    checks++;
    if (busy !== 1'b0 || pipe_flush_ack !== 1'b1) begin
      failures++;
      $display("FAIL midop_reset_state: busy=%b ack=%b, expected 0 1", busy, pipe_flush_ack);
    end
    issue_seq(32'h0000_0800);
    return_rsp();
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_wrap();
    test_outstanding_drop();
    test_rsp_in_accept();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
